l2_tcdm_burst_reader: RTL and testbench

//  TCDM initiator: reads LEN consecutive 32-bit words from an L2 bank (or a private bank)

---
 rtl/l2_tcdm_reader_pkg.sv | 16 +
 rtl/l2_tcdm_burst_reader_if.sv | 26 ++
 rtl/l2_tcdm_reader_fifo.sv | 61 ++++++
 rtl/l2_tcdm_burst_reader.sv | 151 +++++++++++++++
 tb/tb_l2_tcdm_burst_reader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_tcdm_reader_pkg.sv
// l2_tcdm_reader_pkg
//   Shared definitions for the L2/TCDM burst reader: FSM state encoding,
//   TCDM word size and the all-lanes byte-enable constant.
package l2_tcdm_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    ABORT = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES  = 4;
  localparam logic [3:0]  TCDM_BE_ALL = 4'hF;

endpackage

// File: rtl/l2_tcdm_burst_reader_if.sv
// l2_tcdm_burst_reader_if
//   XBAR_TCDM_BUS style request/response channel.
//   master : the initiator (drives req/add/wen/be/wdata, receives gnt/r_valid/r_rdata)
//   slave  : the memory side
interface l2_tcdm_burst_reader_if;

  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_rdata
  );

endinterface

// File: rtl/l2_tcdm_reader_fifo.sv
// l2_tcdm_reader_fifo
//   Synchronous response FIFO. Push in cycle N is visible at the head in N+1.
//   Ports:
//     clk_i, rst_i     clock, synchronous active-high reset
//     push_i, wdata_i  write side (ignored when full)
//     pop_i            read side (ignored when empty)
//     flush_i          empties the FIFO; overrides push and pop
//     rdata_o          head word, 0 while empty
//     count_o          words held; empty_o / full_o status
module l2_tcdm_reader_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head is forced to 0 when empty so the storage itself needs no reset.
  assign rdata_o = empty_o ? '0 : mem[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/l2_tcdm_burst_reader.sv
// l2_tcdm_burst_reader
//   TCDM initiator that reads len_i consecutive 32-bit words starting at
//   base_addr_i and returns them in order on a valid/ready stream.
//   Requests are credit-limited: outstanding reads plus buffered words never
//   exceed FIFO_DEPTH, so every response has a slot.
//   Ports:
//     clk_i, rst_i           clock, synchronous active-high reset
//     start_i, base_addr_i,  start pulse with burst base byte address and
//     len_i                  word count (0 completes immediately)
//     abort_i                stop issuing, discard data, wait for in-flight reads
//     busy_o, done_o         burst in progress / completion pulse
//     tcdm                   TCDM master port (read-only use)
//     data_o, valid_o,       output word stream
//     ready_i
module l2_tcdm_burst_reader
  import l2_tcdm_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [31:0]           base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  l2_tcdm_burst_reader_if.master tcdm,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_ABORT = ABORT;

  logic [1:0]           state_q, state_d;
  logic [31:0]          addr_q;
  logic [LEN_WIDTH-1:0] len_q, issued_q;
  logic [CNT_W-1:0]     outst_q, fifo_count;
  logic                 done_q, done_d;
  logic [CNT_W:0]       credit_used;
  logic                 hs, rsp_ok, last_hs, start_take, abort_take;
  logic                 fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;

  // req only depends on state and credits, so once raised it stays up with a
  // stable address until granted: without a handshake the credit sum cannot grow.
  assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
  assign tcdm.req    = (state_q == ST_ISSUE) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign tcdm.add    = addr_q;
  assign tcdm.wen    = 1'b1;
  assign tcdm.be     = TCDM_BE_ALL;
  assign tcdm.wdata  = '0;

  assign hs         = tcdm.req && tcdm.gnt;
  // A response with nothing outstanding is a protocol error (or a leftover
  // from before a reset) and is dropped.
  assign rsp_ok     = tcdm.r_valid && (outst_q != '0);
  assign last_hs    = hs && ((issued_q + LEN_WIDTH'(1)) == len_q);
  assign start_take = start_i && (state_q == ST_IDLE);
  assign abort_take = abort_i && (state_q != ST_IDLE);

  assign fifo_push  = rsp_ok && (state_q != ST_ABORT) && !fifo_full;
  assign fifo_pop   = valid_o && ready_i;
  assign fifo_flush = abort_take || (state_q == ST_ABORT);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) state_d = ST_ISSUE;
          else             done_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (abort_i)      state_d = ST_ABORT;
        else if (last_hs) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d = ST_ABORT;
        end else if ((outst_q == '0) && fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ABORT: begin
        if (outst_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      outst_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_take) begin
        addr_q   <= base_addr_i & ~32'(WORD_BYTES - 1);
        len_q    <= len_i;
        issued_q <= '0;
      end else if (hs) begin
        addr_q   <= addr_q + 32'(WORD_BYTES);
        issued_q <= issued_q + LEN_WIDTH'(1);
      end
      case ({hs, rsp_ok})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  l2_tcdm_reader_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (tcdm.r_rdata),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .rdata_o (data_o),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign valid_o = !fifo_empty;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;

endmodule

// File: tb/tb_l2_tcdm_burst_reader.sv
// tb_l2_tcdm_burst_reader
//   Directed bench for l2_tcdm_burst_reader with a TCDM memory model
//   (configurable grant probability and in-order response latency) and a
//   scoreboard of expected stream words filled at request handshake time.
module tb_l2_tcdm_burst_reader;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_WIDTH  = 16;

  logic        clk = 1'b0;
  logic        rst_i, start_i, abort_i, ready_i;
  logic [31:0] base_addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, valid_o;
  logic [31:0] data_o;
  logic        gnt_en;

  l2_tcdm_burst_reader_if tcdm ();
  assign tcdm.gnt = tcdm.req & gnt_en;

  l2_tcdm_burst_reader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tcdm        (tcdm),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, last_due = -1;
  int          lat_min = 1, lat_max = 1;
  bit          rand_gnt = 1'b0, ready_en = 1'b1;
  logic [31:0] exp_q [$];
  int          pend_due [$];
  logic [31:0] pend_dat [$];
  logic [31:0] hs_addr_q [$];
  logic [31:0] exp_addr;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_add;
  int          hs_cnt, beats, done_cnt, req_cnt, valid_cnt, busy_cnt, max_out;
  int          first_beat, last_beat;
  logic        s_req, s_valid, s_busy, s_done, s_wen;
  logic [3:0]  s_be;
  logic [31:0] s_add, s_data;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic clr();
    hs_cnt = 0; beats = 0; done_cnt = 0; req_cnt = 0; valid_cnt = 0;
    busy_cnt = 0; max_out = 0; first_beat = 0; last_beat = 0;
    hs_addr_q.delete();
  endtask

  // One clock cycle: sample DUT outputs mid-cycle, drive the memory model and
  // consumer for this cycle, and account for the handshakes that will occur.
  task automatic tick();
    int lat, due;
    @(negedge clk);
    s_req = tcdm.req; s_add = tcdm.add; s_wen = tcdm.wen; s_be = tcdm.be;
    s_valid = valid_o; s_data = data_o; s_busy = busy_o; s_done = done_o;
    gnt_en  = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    ready_i = ready_en;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      tcdm.r_valid = 1'b1;
      tcdm.r_rdata = pend_dat.pop_front();
      void'(pend_due.pop_front());
    end else begin
      tcdm.r_valid = 1'b0;
      tcdm.r_rdata = 32'h0;
    end
    if (hold_prev) begin
      check("req_held", 32'(s_req), 32'd1);
      check("add_held", s_add, hold_add);
    end
    hold_prev = s_req && !gnt_en;
    hold_add  = s_add;
    if (s_req && gnt_en) begin
      check("add_seq", s_add, exp_addr);
      hs_addr_q.push_back(s_add);
      exp_q.push_back(rd_word(exp_addr));
      exp_addr += 32'd4;
      hs_cnt++;
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_due.push_back(due);
      pend_dat.push_back(rd_word(s_add));
    end
    if (s_valid && ready_i) begin
      if (exp_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
      else check("stream_data", s_data, exp_q.pop_front());
      if (beats == 0) first_beat = cyc;
      last_beat = cyc;
      beats++;
    end
    if (s_done)  done_cnt++;
    if (s_req)   req_cnt++;
    if (s_valid) valid_cnt++;
    if (s_busy)  busy_cnt++;
    if (pend_due.size() > max_out) max_out = pend_due.size();
    cyc++;
  endtask

  task automatic start_burst(input logic [31:0] base, input logic [15:0] len);
    clr();
    exp_addr    = base & 32'hFFFF_FFFC;
    base_addr_i = base;
    len_i       = len;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic run_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) tick();
    check({tag, "_done_once"}, done_cnt, 32'd1);
    check({tag, "_busy_idle"}, 32'(s_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(s_req),   32'd0);
    check({tag, "_add"},   s_add,        32'd0);
    check({tag, "_busy"},  32'(s_busy),  32'd0);
    check({tag, "_done"},  32'(s_done),  32'd0);
    check({tag, "_valid"}, 32'(s_valid), 32'd0);
    check({tag, "_data"},  s_data,       32'd0);
  endtask

  logic [31:0] t6_exp [4];

  initial begin
    int n;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
    base_addr_i = '0; len_i = '0; gnt_en = 1'b1;
    tcdm.r_valid = 1'b0; tcdm.r_rdata = '0;
    t6_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    clr();
    repeat (3) tick();
    rst_i = 1'b0;
    hold_prev = 1'b0;
    tick();
    check_reset_outputs("rst");
    check("rst_wen", 32'(s_wen), 32'd1);
    check("rst_be",  32'(s_be),  32'hF);

    // Basic 8-word burst at full rate
    start_burst(32'h1C01_0000, 16'd8);
    run_done("t1", 60);
    check("t1_hs", hs_cnt, 32'd8);
    check("t1_beats", beats, 32'd8);
    check("t1_back_to_back", last_beat - first_beat, 32'd7);
    check("t1_sb_empty", exp_q.size(), 32'd0);

    // Zero-length start
    start_burst(32'h1C01_0040, 16'd0);
    tick();
    check("t2_done_next", done_cnt, 32'd1);
    repeat (3) tick();
    check("t2_done_once", done_cnt, 32'd1);
    check("t2_no_req", req_cnt, 32'd0);
    check("t2_no_busy", busy_cnt, 32'd0);

    // Consumer stalled: credit limit stops issue at FIFO_DEPTH
    ready_en = 1'b0;
    start_burst(32'h1C01_0100, 16'd16);
    repeat (20) tick();
    check("t3_hs_limit", hs_cnt, 32'd4);
    check("t3_req_low", 32'(s_req), 32'd0);
    check("t3_valid", 32'(s_valid), 32'd1);
    ready_en = 1'b1;
    run_done("t3", 100);
    check("t3_beats", beats, 32'd16);
    check("t3_sb_empty", exp_q.size(), 32'd0);

    // Random grant, 1..3 cycle response latency
    rand_gnt = 1'b1; lat_min = 1; lat_max = 3;
    start_burst(32'h0000_2000, 16'd24);
    run_done("t4", 400);
    check("t4_beats", beats, 32'd24);
    check("t4_max_out", 32'(max_out <= FIFO_DEPTH), 32'd1);
    check("t4_sb_empty", exp_q.size(), 32'd0);
    rand_gnt = 1'b0;

    // Abort with two reads in flight
    lat_min = 2; lat_max = 2;
    start_burst(32'h0000_3000, 16'd12);
    n = 0;
    while (hs_cnt < 5 && n < 50) begin
      tick();
      n++;
    end
    check("t5_hs5", hs_cnt, 32'd5);
    check("t5_outstanding", pend_due.size(), 32'd2);
    abort_i = 1'b1;
    hold_prev = 1'b0;
    exp_q.delete();
    req_cnt = 0; valid_cnt = 0;
    tick();
    abort_i = 1'b0;
    run_done("t5", 40);
    check("t5_no_req", req_cnt, 32'd0);
    check("t5_no_valid", valid_cnt, 32'd0);
    check("t5_late_rsp_sent", pend_due.size(), 32'd0);
    lat_min = 1; lat_max = 1;
    start_burst(32'h0000_3800, 16'd2);
    run_done("t5b", 40);
    check("t5b_beats", beats, 32'd2);
    check("t5b_sb_empty", exp_q.size(), 32'd0);

    // Address wrap across 2^32
    start_burst(32'hFFFF_FFF8, 16'd4);
    run_done("t6", 40);
    check("t6_hs", hs_addr_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_addr_q.size()) check("t6_wrap_add", hs_addr_q[i], t6_exp[i]);
    end
    check("t6_beats", beats, 32'd4);

    // Reset in the middle of a burst, late responses must be ignored
    lat_min = 3; lat_max = 3;
    start_burst(32'h0000_5000, 16'd8);
    n = 0;
    while (hs_cnt < 3 && n < 50) begin
      tick();
      n++;
    end
    check("t7_hs3", hs_cnt, 32'd3);
    rst_i = 1'b1;
    hold_prev = 1'b0;
    tick();
    rst_i = 1'b0;
    check_reset_outputs("t7_rst");
    exp_q.delete();
    valid_cnt = 0; req_cnt = 0; done_cnt = 0;
    repeat (6) tick();
    check("t7_late_rsp_sent", pend_due.size(), 32'd0);
    check("t7_no_valid", valid_cnt, 32'd0);
    check("t7_no_req", req_cnt, 32'd0);
    check("t7_no_done", done_cnt, 32'd0);
    check("t7_busy", 32'(s_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
